// File: rtl/store_unit.sv
// store_unit: aligns RV32 stores to byte lanes behind a two-entry (output + skid) buffer.
// Define STORE_MISALIGN_TRAP_EN to drop misaligned SH/SW with an o_err pulse instead of forcing alignment.
module store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_wdata,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_we,
  output logic              o_err,
  output logic              o_idle
);
  localparam int W = ADDR_W + 36;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_e;
  state_e state_q, state_d;
  logic [W-1:0] out_q, out_d, skid_q, skid_d, new_e;
  logic [3:0] new_we;
  logic [31:0] new_wdata;
  logic err_q, err_d, legal, accept, take;
  always_comb begin
    new_we = i_funct3[1] ? 4'b1111 : i_funct3[0] ? 4'b0011 << {i_addr[1], 1'b0} : 4'b0001 << i_addr[1:0];
    new_wdata = i_funct3[1] ? i_wdata : i_funct3[0] ? {2{i_wdata[15:0]}} : {4{i_wdata[7:0]}};
    new_e = {i_addr[ADDR_W-1:2], 2'b00, new_wdata, new_we};
`ifdef STORE_MISALIGN_TRAP_EN
    legal = !i_funct3[2] && i_funct3[1:0] != 2'b11 && !(i_funct3[0] && i_addr[0]) && !(i_funct3[1] && i_addr[1:0] != 2'b00);
`else
    legal = !i_funct3[2] && i_funct3[1:0] != 2'b11;
`endif
  end
  assign o_ready     = state_q != FULL;
  assign o_idle      = state_q == EMPTY;
  assign o_mem_valid = state_q != EMPTY;
  assign o_err       = err_q;
  assign {o_mem_addr, o_mem_wdata, o_mem_we} = out_q;
  assign accept = i_valid && o_ready;
  assign take   = accept && legal;
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    err_d   = accept && !legal;
    case (state_q)
      EMPTY: if (take) begin
        state_d = BUSY;
        out_d   = new_e;
      end
      BUSY: if (take && i_mem_ready) out_d = new_e;
      else if (take) begin
        state_d = FULL;
        skid_d  = new_e;
      end else if (i_mem_ready) state_d = EMPTY;
      FULL: if (i_mem_ready) begin
        state_d = BUSY;
        out_d   = skid_q;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_store_unit;
  logic        clk = 0, rst_n = 0, i_valid = 0, i_mem_ready = 0;
  logic [31:0] i_addr = 0, i_wdata = 0;
  logic [2:0]  i_funct3 = 0;
  logic        o_ready, o_mem_valid, o_err, o_idle;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_we;
  int tests = 0, fails = 0;

  store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_addr(i_addr),
    .i_funct3(i_funct3), .i_wdata(i_wdata), .o_mem_valid(o_mem_valid), .i_mem_ready(i_mem_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_err(o_err), .o_idle(o_idle)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    i_valid = v; i_funct3 = f3; i_addr = a; i_wdata = d;
  endtask

  task automatic settle;
    drive(0, 0, 0, 0);
    i_mem_ready = 1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_idle, o_ready} !== {1'b0, 4'h0, 64'h0, 1'b0, 2'b11}) begin
      fails++;
      $display("FAIL reset: valid=%b we=%b addr=%h wdata=%h err=%b idle=%b ready=%b, required 0/0/0/0/0/1/1",
               o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_idle, o_ready);
    end
    rst_n = 1;
  endtask

  task automatic test_sb;
    i_mem_ready = 1;
    drive(1, 3'b000, 32'h1003, 32'h0000_00A5);
    @(negedge clk);
    drive(0, 0, 0, 0);
    tests++;
    if ({o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata} !== {1'b1, 32'h1000, 4'b1000, 32'hA5A5_A5A5}) begin
      fails++;
      $display("FAIL sb: valid=%b addr=%h we=%b wdata=%h, required 1 00001000 1000 a5a5a5a5",
               o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata);
    end
    settle();
  endtask

  task automatic test_sh;
    i_mem_ready = 1;
    drive(1, 3'b001, 32'h2002, 32'h1234_BEEF);
    @(negedge clk);
    drive(0, 0, 0, 0);
    tests++;
    if ({o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata} !== {1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF}) begin
      fails++;
      $display("FAIL sh: valid=%b addr=%h we=%b wdata=%h, required 1 00002000 1100 beefbeef",
               o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata);
    end
    @(negedge clk);
    tests++;
    if ({o_mem_valid, o_idle} !== 2'b01) begin
      fails++;
      $display("FAIL sh_drain: valid=%b idle=%b, required valid=0 idle=1", o_mem_valid, o_idle);
    end
    settle();
  endtask

  task automatic test_backpressure;
    i_mem_ready = 0;
    drive(1, 3'b010, 32'h10, 32'hAAAA_0001);
    @(negedge clk);
    tests++;
    if ({o_mem_valid, o_mem_addr, o_mem_wdata} !== {1'b1, 32'h10, 32'hAAAA_0001}) begin
      fails++;
      $display("FAIL bp_a: valid=%b addr=%h wdata=%h, required 1 00000010 aaaa0001", o_mem_valid, o_mem_addr, o_mem_wdata);
    end
    drive(1, 3'b010, 32'h14, 32'hBBBB_0002);
    @(negedge clk);
    tests++;
    if ({o_ready, o_mem_valid, o_mem_addr, o_mem_wdata} !== {2'b01, 32'h10, 32'hAAAA_0001}) begin
      fails++;
      $display("FAIL bp_full: ready=%b valid=%b addr=%h wdata=%h, required ready=0 1 00000010 aaaa0001",
               o_ready, o_mem_valid, o_mem_addr, o_mem_wdata);
    end
    drive(0, 0, 0, 0);
    i_mem_ready = 1;
    @(negedge clk);
    tests++;
    if ({o_ready, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_we} !== {2'b11, 32'h14, 32'hBBBB_0002, 4'hF}) begin
      fails++;
      $display("FAIL bp_b: ready=%b valid=%b addr=%h wdata=%h we=%b, required 1 1 00000014 bbbb0002 1111",
               o_ready, o_mem_valid, o_mem_addr, o_mem_wdata, o_mem_we);
    end
    @(negedge clk);
    tests++;
    if ({o_mem_valid, o_idle} !== 2'b01) begin
      fails++;
      $display("FAIL bp_drain: valid=%b idle=%b, required 0 1", o_mem_valid, o_idle);
    end
    settle();
  endtask

  task automatic test_illegal;
    drive(1, 3'b011, 32'h500, 32'h1);
    @(negedge clk);
    drive(0, 0, 0, 0);
    tests++;
    if ({o_err, o_mem_valid, o_idle, o_ready} !== 4'b1011) begin
      fails++;
      $display("FAIL illegal: err=%b valid=%b idle=%b ready=%b, required 1 0 1 1", o_err, o_mem_valid, o_idle, o_ready);
    end
    @(negedge clk);
    tests++;
    if ({o_err, o_mem_valid} !== 2'b00) begin
      fails++;
      $display("FAIL illegal_pulse: err=%b valid=%b, required 0 0", o_err, o_mem_valid);
    end
    settle();
  endtask

  task automatic test_misalign;
    drive(1, 3'b010, 32'h3001, 32'hCAFE_F00D);
    @(negedge clk);
    drive(0, 0, 0, 0);
    tests++;
`ifdef STORE_MISALIGN_TRAP_EN
    if ({o_err, o_mem_valid} !== 2'b10) begin
      fails++;
      $display("FAIL misalign_trap: err=%b valid=%b, required 1 0", o_err, o_mem_valid);
    end
`else
    if ({o_err, o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata} !== {2'b01, 32'h3000, 4'hF, 32'hCAFE_F00D}) begin
      fails++;
      $display("FAIL misalign: err=%b valid=%b addr=%h we=%b wdata=%h, required 0 1 00003000 1111 cafef00d",
               o_err, o_mem_valid, o_mem_addr, o_mem_we, o_mem_wdata);
    end
`endif
    settle();
  endtask

  task automatic test_reset_in_full;
    i_mem_ready = 0;
    drive(1, 3'b010, 32'h40, 32'h1111_1111);
    @(negedge clk);
    drive(1, 3'b010, 32'h44, 32'h2222_2222);
    @(negedge clk);
    drive(0, 0, 0, 0);
    tests++;
    if (o_ready !== 1'b0) begin
      fails++;
      $display("FAIL rif_full: ready=%b, required 0", o_ready);
    end
    rst_n = 0;
    #1;
    tests++;
    if ({o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_idle, o_ready} !== {1'b0, 4'h0, 64'h0, 1'b0, 2'b11}) begin
      fails++;
      $display("FAIL rif_async: valid=%b we=%b addr=%h wdata=%h err=%b idle=%b ready=%b, required 0/0/0/0/0/1/1",
               o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata, o_err, o_idle, o_ready);
    end
    @(negedge clk);
    rst_n = 1;
    i_mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (o_mem_valid !== 1'b0) begin
        fails++;
        $display("FAIL rif_after cyc %0d: valid=%b, required 0", k, o_mem_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [67:0] q[$];
    logic [67:0] exp_e, ent;
    logic err_exp, acc, pop, ok;
    int sz, off, r;
    err_exp = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      exp_e = q.size() > 0 ? q[0] : 68'h0;
      tests++;
      if (o_mem_valid !== (q.size() > 0) || o_ready !== (q.size() < 2) || o_idle !== (q.size() == 0) ||
          o_err !== err_exp || (q.size() > 0 && {o_mem_addr, o_mem_wdata, o_mem_we} !== exp_e)) begin
        fails++;
        $display("FAIL random cyc %0d: valid=%b ready=%b idle=%b err=%b out=%h, required depth=%0d err=%b out=%h",
                 n, o_mem_valid, o_ready, o_idle, o_err, {o_mem_addr, o_mem_wdata, o_mem_we}, q.size(), err_exp, exp_e);
      end
      r = $urandom_range(0, 9);
      drive($urandom_range(0, 3) != 0, r < 3 ? 3'd0 : r < 6 ? 3'd1 : r < 9 ? 3'd2 : 3'($urandom_range(3, 7)),
            $urandom, $urandom);
      i_mem_ready = $urandom_range(0, 2) != 0;
      sz  = i_funct3 == 0 ? 1 : i_funct3 == 1 ? 2 : 4;
      ok  = i_funct3 <= 2;
`ifdef STORE_MISALIGN_TRAP_EN
      ok  = ok && (i_addr % sz) == 0;
`endif
      off = (int'(i_addr % 4) / sz) * sz;
      ent = {i_addr & ~32'h3, 36'h0};
      for (int b = 0; b < 4; b++) begin
        ent[4 + 8*b +: 8] = i_wdata[8*(b % sz) +: 8];
        ent[b] = b >= off && b < off + sz;
      end
      acc = i_valid && q.size() < 2;
      pop = q.size() > 0 && i_mem_ready;
      err_exp = acc && !ok;
      if (pop) void'(q.pop_front());
      if (acc && ok) q.push_back(ent);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh();
    test_backpressure();
    test_illegal();
    test_misalign();
    test_reset_in_full();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
